// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cam_pkg
//  Description : Shared constants, FSM state encoding and pixel-format helper
//                for the camera capture stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package cam_pkg;

    localparam int H_PIX_DEF   = 160;
    localparam int V_LINES_DEF = 120;
    localparam int FRAME_PIX   = H_PIX_DEF * V_LINES_DEF;  // 19200

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        SYNC    = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } cam_state_e;

    // b0 = RRRRRGGG, b1 = GGGBBBBB; keep the top 3 red, top 3 green, top 2 blue.
    function automatic logic [7:0] rgb565_to_332(input logic [7:0] b0,
                                                 input logic [7:0] b1);
        return {b0[7:5], b0[2:0], b1[4:3]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cam_sync.sv
`default_nettype none
// ============================================================================
//  Module      : cam_sync
//  Description : Two-flop synchroniser for an asynchronous camera pin, plus a
//                delay stage that yields single-cycle rise/fall pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module cam_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    // [0],[1] are the metastability stages, [2] is the edge-detect delay.
    logic [2:0] pipe_q;

    // Shift the raw pin through the synchroniser and delay stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= 3'b000;
        end else begin
            pipe_q <= {pipe_q[1:0], d_i};
        end
    end

    assign level_o = pipe_q[1];
    assign rise_o  =  pipe_q[1] & ~pipe_q[2];
    assign fall_o  = ~pipe_q[1] &  pipe_q[2];

endmodule
`default_nettype wire

// File: rtl/cam_capture.sv
`default_nettype none
// ============================================================================
//  Module      : cam_capture
//  Description : Camera pixel-capture stage. Generates Xclk, oversamples
//                Pclk/Vsync/Href, packs RGB565 byte pairs to RGB332 and writes
//                one frame into the frame buffer per start request.
//  Revision    : 1.0 - initial release
// ============================================================================
module cam_capture
    import cam_pkg::*;
#(
    parameter int H_PIX    = H_PIX_DEF,
    parameter int V_LINES  = V_LINES_DEF,
    parameter int ADDR_W   = 15,
    parameter int XCLK_DIV = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic              camera_Xclk,
    input  logic              camera_Pclk,
    input  logic              camera_Vsync,
    input  logic              camera_Href,
    input  logic [7:0]        cam_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              frame_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data
);

    localparam int XCLK_HALF = XCLK_DIV / 2;
    // One past the last legal address; also the expected pixel count.
    localparam logic [ADDR_W-1:0] FRAME_END = ADDR_W'(H_PIX * V_LINES);

    // ------------------------------------------------------------------------
    // Camera master clock
    // ------------------------------------------------------------------------
    logic [15:0] xdiv_q;
    logic        xclk_q;

    // Free-running divider: toggle Xclk every XCLK_DIV/2 system clocks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xdiv_q <= 16'd0;
            xclk_q <= 1'b0;
        end else if (xdiv_q == 16'(XCLK_HALF - 1)) begin
            xdiv_q <= 16'd0;
            xclk_q <= ~xclk_q;
        end else begin
            xdiv_q <= xdiv_q + 16'd1;
        end
    end

    assign camera_Xclk = xclk_q;

    // ------------------------------------------------------------------------
    // Pin synchronisers
    // ------------------------------------------------------------------------
    logic pclk_lvl, pclk_rise, pclk_fall;
    logic vs_lvl,   vs_rise,   vs_fall;
    logic href_lvl, href_rise, href_fall;

    cam_sync u_sync_pclk (
        .clk     (clk),
        .rst_n   (reset),
        .d_i     (camera_Pclk),
        .level_o (pclk_lvl),
        .rise_o  (pclk_rise),
        .fall_o  (pclk_fall)
    );

    cam_sync u_sync_vsync (
        .clk     (clk),
        .rst_n   (reset),
        .d_i     (camera_Vsync),
        .level_o (vs_lvl),
        .rise_o  (vs_rise),
        .fall_o  (vs_fall)
    );

    cam_sync u_sync_href (
        .clk     (clk),
        .rst_n   (reset),
        .d_i     (camera_Href),
        .level_o (href_lvl),
        .rise_o  (href_rise),
        .fall_o  (href_fall)
    );

    // Synchroniser taps this stage has no use for.
    logic unused_sync;
    assign unused_sync = &{1'b0, pclk_lvl, pclk_fall, vs_lvl, href_rise};

    // Data bus gets the same two-flop delay so it lines up with pclk_rise.
    logic [7:0] data_s1_q, data_s2_q;

    // Two-stage copy of the camera data bus.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_s1_q <= 8'h00;
            data_s2_q <= 8'h00;
        end else begin
            data_s1_q <= cam_data;
            data_s2_q <= data_s1_q;
        end
    end

    // ------------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------------
    cam_state_e        state_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              phase_q;     // 0: expecting first byte of a pixel
    logic [7:0]        hold_q;      // first byte of the current pixel
    logic [ADDR_W-1:0] wr_ptr_q;    // next address to write, saturates at FRAME_END
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_data_q;

    // Frame sequencing, byte pairing and frame-buffer write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            phase_q    <= 1'b0;
            hold_q     <= 8'h00;
            wr_ptr_q   <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= 8'h00;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= ARM;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                // A frame already in flight is skipped: only a fresh Vsync counts.
                ARM: begin
                    if (vs_rise) begin
                        state_q <= SYNC;
                    end
                end
                SYNC: begin
                    if (vs_fall) begin
                        state_q    <= CAPTURE;
                        wr_ptr_q   <= '0;
                        mem_addr_q <= '0;
                        phase_q    <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (vs_rise) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        if (wr_ptr_q != FRAME_END) begin
                            err_q <= 1'b1;
                        end
                    end else if (href_fall) begin
                        // Line ended: an unpaired trailing byte is discarded.
                        phase_q <= 1'b0;
                    end else if (pclk_rise && href_lvl) begin
                        if (!phase_q) begin
                            hold_q  <= data_s2_q;
                            phase_q <= 1'b1;
                        end else begin
                            phase_q <= 1'b0;
                            if (wr_ptr_q != FRAME_END) begin
                                mem_we_q   <= 1'b1;
                                mem_addr_q <= wr_ptr_q;
                                mem_data_q <= rgb565_to_332(hold_q, data_s2_q);
                                wr_ptr_q   <= wr_ptr_q + 1'b1;
                            end else begin
                                // Frame overran the buffer; drop the pixel.
                                err_q <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        // A coincident Vsync rise is taken as the ARM trigger.
                        state_q <= vs_rise ? SYNC : ARM;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_err = err_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;

endmodule
`default_nettype wire

// File: tb/tb_cam_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cam_capture
//  Description : Self-checking bench for cam_capture. A camera model drives a
//                reduced 8x6 frame geometry; a behavioural model predicts every
//                frame-buffer write (address, RGB332 value, arrival cycle).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_capture;

    localparam int H     = 8;
    localparam int V     = 6;
    localparam int FRAME = H * V;   // 48 pixels
    localparam int XDIV  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        camera_Xclk;
    logic        camera_Pclk = 1'b0;
    logic        camera_Vsync = 1'b0;
    logic        camera_Href = 1'b0;
    logic [7:0]  cam_data = 8'h00;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        frame_err;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [7:0]  mem_data;

    always #5 clk = ~clk;

    cam_capture #(
        .H_PIX    (H),
        .V_LINES  (V),
        .ADDR_W   (15),
        .XCLK_DIV (XDIV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .camera_Xclk  (camera_Xclk),
        .camera_Pclk  (camera_Pclk),
        .camera_Vsync (camera_Vsync),
        .camera_Href  (camera_Href),
        .cam_data     (cam_data),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .frame_err    (frame_err),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int addr;
        int data;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   m_addr = 0;
    bit   m_err  = 0;
    bit   m_cap  = 0;
    int   n_writes   = 0;
    int   last_addr  = -1;
    int   first_addr = -1;
    int   odd_line   = -1;
    int   start_line = -1;

    // RGB565 pair -> RGB332: top 3 red, top 3 green, top 2 blue.
    function automatic int pix(input int b0, input int b1);
        return (b0 / 32) * 32 + (b0 % 8) * 4 + ((b1 / 8) % 4);
    endfunction

    function automatic int byte_val(input int pat, input int seed, input int ln, input int i);
        if (pat == 0) return (i % 2 == 0) ? 'hF8 : 'h1F;
        return (seed + ln * 29 + i * 13 + i * i) % 256;
    endfunction

    // Every write is compared against the model's next expected pixel.
    always @(negedge clk) begin
        exp_t e;
        if (reset && mem_we) begin
            n_writes++;
            last_addr = int'(mem_addr);
            if (first_addr < 0) first_addr = int'(mem_addr);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%0d expected=none", mem_addr, mem_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", int'(mem_addr), e.addr);
                chk("wr_data", int'(mem_data), e.data);
                chk("wr_latency_cycle", cyc, e.cyc);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("done_after_start", done, 0);
    endtask

    task automatic vsync_pulse();
        camera_Vsync = 1'b1;
        tick(6);
        camera_Vsync = 1'b0;
        tick(6);
    endtask

    task automatic send_line(input int ln, input int nbytes, input int pat, input int seed);
        int b0 = 0;
        camera_Href = 1'b1;
        for (int i = 0; i < nbytes; i++) begin
            int b = byte_val(pat, seed, ln, i);
            cam_data    = 8'(b);
            camera_Pclk = 1'b0;
            if (ln == start_line && i == 5) begin
                start = 1'b1;
                tick(1);
                start = 1'b0;
                chk("busy_after_midstart", busy, 1);
                chk("done_after_midstart", done, 0);
                tick(1);
            end else begin
                tick(2);
            end
            camera_Pclk = 1'b1;
            if (i % 2 == 0) begin
                b0 = b;
            end else if (m_cap) begin
                if (m_addr < FRAME) begin
                    exp_q.push_back('{m_addr, pix(b0, b), cyc + 3});
                    m_addr++;
                end else begin
                    m_err = 1'b1;
                end
            end
            tick(2);
        end
        camera_Pclk = 1'b0;
        tick(2);
        camera_Href = 1'b0;
        tick(4);
    endtask

    task automatic send_frame(input int nlines, input int pat, input int seed, input bit cap);
        vsync_pulse();
        m_addr     = 0;
        m_err      = 1'b0;
        m_cap      = cap;
        n_writes   = 0;
        first_addr = -1;
        for (int ln = 0; ln < nlines; ln++) begin
            send_line(ln, (ln == odd_line) ? 2 * H + 1 : 2 * H, pat, seed);
        end
    endtask

    task automatic end_frame();
        vsync_pulse();
        m_cap = 1'b0;
        chk("done_at_end", done, 1);
        chk("busy_at_end", busy, 0);
        chk("frame_err_at_end", frame_err, (m_err || m_addr != FRAME) ? 1 : 0);
        chk("pending_writes", exp_q.size(), 0);
    endtask

    initial begin
        int hi = 0;
        int lo = 0;
        int guard = 0;

        // Reset values
        tick(3);
        chk("rst_xclk", camera_Xclk, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_data", int'(mem_data), 0);
        reset = 1'b1;
        tick(2);

        // Xclk: 4 clk period, 2 high / 2 low
        @(negedge clk);
        while (camera_Xclk && guard < 20) begin @(negedge clk); guard++; end
        while (!camera_Xclk && guard < 40) begin @(negedge clk); guard++; end
        while (camera_Xclk && guard < 60) begin hi++; @(negedge clk); guard++; end
        while (!camera_Xclk && guard < 80) begin lo++; @(negedge clk); guard++; end
        chk("xclk_high_cycles", hi, 2);
        chk("xclk_low_cycles", lo, 2);
        tick(1);

        // Model pinned to a hand-computed value
        chk("model_pix_F8_1F", pix('hF8, 'h1F), 'hE3);

        // Full frame of 0xF8,0x1F pairs
        start_pulse();
        send_frame(V, 0, 0, 1'b1);
        end_frame();
        chk("full_n_writes", n_writes, 48);
        chk("full_last_addr", last_addr, 47);
        chk("full_frame_err", frame_err, 0);

        // Start from DONE while a frame is mid-line: that frame is skipped
        start_line = 2;
        send_frame(V, 1, 3, 1'b0);
        start_line = -1;
        send_frame(V, 1, 7, 1'b1);
        end_frame();
        chk("midstart_first_addr", first_addr, 0);
        chk("midstart_n_writes", n_writes, 48);

        // Short frame: 5 lines
        start_pulse();
        send_frame(V - 1, 1, 21, 1'b1);
        end_frame();
        chk("short_last_addr", last_addr, 39);
        chk("short_frame_err", frame_err, 1);

        // Long frame: 7 lines, writes saturate
        start_pulse();
        send_frame(V + 1, 1, 55, 1'b1);
        end_frame();
        chk("long_n_writes", n_writes, 48);
        chk("long_last_addr", last_addr, 47);
        chk("long_frame_err", frame_err, 1);

        // Odd-length line plus an ignored start during CAPTURE
        start_pulse();
        odd_line   = 1;
        start_line = 3;
        send_frame(V, 1, 91, 1'b1);
        odd_line   = -1;
        start_line = -1;
        end_frame();
        chk("odd_n_writes", n_writes, 48);
        chk("odd_frame_err", frame_err, 0);

        // Reset mid-capture
        start_pulse();
        vsync_pulse();
        m_addr = 0;
        m_err  = 1'b0;
        m_cap  = 1'b1;
        send_line(0, 2 * H, 1, 13);
        send_line(1, 2 * H, 1, 13);
        reset = 1'b0;
        #2;
        chk("midrst_xclk", camera_Xclk, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_frame_err", frame_err, 0);
        chk("midrst_mem_we", mem_we, 0);
        chk("midrst_mem_addr", int'(mem_addr), 0);
        chk("midrst_mem_data", int'(mem_data), 0);
        chk("midrst_pending", exp_q.size(), 0);
        m_cap = 1'b0;
        tick(3);
        reset = 1'b1;
        send_frame(V, 1, 33, 1'b0);
        vsync_pulse();
        chk("postrst_n_writes", n_writes, 0);
        chk("postrst_busy", busy, 0);
        chk("postrst_done", done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/cam_capture.md
# cam_capture

Pixel-capture stage between the OV7670-style camera pins and the frame-buffer RAM read by the Wishbone camera peripheral. It generates the camera master clock, oversamples Pclk/Vsync/Href in the system clock domain, packs RGB565 byte pairs into RGB332 pixels, and writes one 160x120 frame (19200 bytes, addresses 0x0000–0x4AFF) per `start` request. It drives the `done` level that the peripheral exposes as its "picture available" register.

## Interface
- `H_PIX`, 160, pixels per line
- `V_LINES`, 120, lines per frame
- `ADDR_W`, 15, frame-buffer address width
- `XCLK_DIV`, 2, clk cycles per camera_Xclk period (even, ≥2)
- `clk`  in  1  system clock, single clock domain; must be ≥4× Pclk
- `reset`  in  1  asynchronous, active-low reset
- `camera_Xclk`  out  1  camera master clock
- `camera_Pclk`  in  1  camera pixel clock, asynchronous, sampled
- `camera_Vsync`  in  1  frame sync, active high
- `camera_Href`  in  1  line valid, active high
- `cam_data`  in  8  camera data bus
- `start`  in  1  one-cycle capture request
- `busy`  out  1  high from accepted `start` until frame end
- `done`  out  1  frame complete, held until next accepted `start`
- `frame_err`  out  1  last frame pixel count ≠ H_PIX*V_LINES
- `mem_we`  out  1  frame-buffer write strobe, one cycle per pixel
- `mem_addr`  out  ADDR_W  write address
- `mem_data`  out  8  RGB332 pixel

## Operation
- Reset values: camera_Xclk=0, busy=0, done=0, frame_err=0, mem_we=0, mem_addr=0, mem_data=0, FSM=IDLE.
- camera_Xclk toggles every XCLK_DIV/2 clk cycles, always running except in reset.
- Pclk, Vsync and Href each pass through a 2-FF synchroniser plus a delay register giving rise/fall pulses. cam_data is captured from a 2-FF copy aligned to the synchronised Pclk.
- FSM:
  - IDLE: `start` → ARM; busy=1, done=0, frame_err=0.
  - ARM: wait for Vsync rise → SYNC. Any frame already in progress is skipped.
  - SYNC: Vsync fall → CAPTURE; mem_addr=0, byte phase=0.
  - CAPTURE: on Pclk rise with Href=1:
    - Phase 0: store byte b0 in a holding register.
    - Phase 1: write `{b0[7:5], b0[2:0], b1[4:3]}` to `mem_addr`, then mem_addr+1.
    - Phase toggles on every captured byte and is cleared on each Href fall, so an odd trailing byte is dropped.
  - CAPTURE, Vsync rise → DONE; busy=0, done=1. frame_err=1 if the pixel count ≠ 19200.
  - DONE: `start` → ARM, clearing done and frame_err.
- Writes saturate: once mem_addr = H_PIX*V_LINES, further pixels set frame_err and are not written. There is no wrap-around.
- `start` in ARM, SYNC or CAPTURE is ignored.
- Simultaneous `start` and Vsync rise in DONE: start wins, and that Vsync rise counts as ARM's trigger (→ SYNC next cycle).
- Async reset mid-frame: everything returns to reset values immediately, and no partial `done` is raised.

## Timing
- Pin Pclk rise to mem_we: 3 clk cycles (2 sync + 1 edge/write register). mem_we, mem_addr and mem_data are registered and valid together for exactly one cycle.
- Vsync rise pin to done=1: 3 clk cycles.
- `start` to busy=1: 1 cycle. done drops in the same cycle.
- Minimum Pclk high and low time: 2 clk cycles. Narrower pulses are undefined.

## Structure
- Package `cam_pkg` holds:
  - H_PIX/V_LINES defaults and FRAME_PIX = 19200.
  - FSM state encoding IDLE/ARM/SYNC/CAPTURE/DONE.
  - The function `rgb565_to_332(b0, b1)`.
- Sub-module `cam_sync`: 2-FF synchroniser with rise/fall pulse outputs. It is instantiated for Pclk, Vsync and Href.
- cam_capture is instantiated inside the Wishbone camera peripheral:
  - `done` → status register.
  - The write to register 0x04 → `start`.
  - `mem_*` → frame-buffer RAM write port.

## Test plan
- Reset: hold reset low mid-capture → all outputs 0, FSM IDLE, no mem_we for 100 cycles after release without `start`.
- Full frame: `start`, camera model sends 120 lines × 320 bytes, with each pixel's byte pair = 0xF8,0x1F → 19200 writes of 0xE3, addresses 0..0x4AFF, then done=1, busy=0, frame_err=0.
- Mid-frame start: assert `start` while Vsync low and Href active → no writes until the next Vsync rise/fall pair; the first write goes to address 0.
- Short/long frame: 119 lines → done=1, frame_err=1, last address 0x4A5F. 121 lines → exactly 19200 writes, frame_err=1.
- Odd line: line with 321 bytes → trailing byte dropped, the next line's first pixel is correctly paired.
- Xclk/latency: XCLK_DIV=4 → Xclk period 4 clk cycles. Pclk rise to mem_we = 3 cycles. `start` during CAPTURE ignored; `start` in DONE clears done in 1 cycle.
